seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 8-digit, common-anode seven-segment display.
- Consumes the 32-bit value selected for display (CPU LED data or one of the performance counters) and shows it as 8 hex digits.
- Runs on the system clock, downstream of the display-source mux.
- Latches data only at frame boundaries so a value changing mid-scan never shows torn.
- Adds an inter-digit blanking gap against ghosting, plus optional leading-zero suppression.

Parameters:
- DIV, 100_000: system-clock cycles per digit slot; must be >= 2.
- BLANK, 1_000: cycles at the start of each slot with all anodes off; 0 <= BLANK < DIV.

Ports:
- clk  input  1  system clock.
- clr  input  1  synchronous, active-high reset.
- data  input  32  value to display; digit i shows data[4i+3:4i]; digit 0 is rightmost.
- blank_lz  input  1  1 = suppress leading zero digits.
- SEG  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}; dp always 1 (off).
- AN  output  8  anodes, active-low; AN[i] enables digit i.
- frame_done  output  1  one-cycle pulse when a new frame and a new shadow value begin.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, clr).
- State registers:
  - cnt, 0..DIV-1, width $clog2(DIV).
  - digit, 0..7.
  - shadow[31:0].
  - registered outputs SEG, AN, frame_done.
- Reset, while clr=1 at a clock edge:
  - cnt=0, digit=0, AN=8'hFF, SEG=8'hFF, frame_done=0.
  - shadow<=data every reset cycle, so it holds data from the last reset cycle.
  - Applies equally mid-frame; the next cycle's outputs are FF/FF.
- Counting, with clr=0:
  - cnt increments each cycle; at DIV-1 it wraps to 0 and digit advances.
  - digit wraps 7->0.
- Frame boundary, when cnt==DIV-1 and digit==7:
  - shadow<=data and frame_done<=1 on the same edge.
  - frame_done is 0 in all other cycles.
  - Shadow changes only here or under reset.
- Output latency: SEG/AN at cycle t+1 are a function of cnt, digit and shadow at cycle t (one registered stage).
- Slot output rule:
  - cnt < BLANK: AN=8'hFF, SEG=8'hFF.
  - Otherwise, if digit is suppressed: AN=8'hFF, SEG=8'hFF.
  - Otherwise: AN=~(8'b1<<digit), SEG=decode(shadow nibble[digit]).
- Suppression: digit i is suppressed iff blank_lz=1, i!=0, and shadow nibbles i..7 are all zero. Digit 0 is never suppressed.
- blank_lz is sampled live, not shadowed.
- Decode, active-low with dp=1:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- At most one AN bit is low at any time; never two.
- With the defaults at 100 MHz: 1 kHz digit rate, 125 Hz frame rate.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry segment code constants.
  - SEG_OFF=8'hFF, AN_OFF=8'hFF.
  - digit index width.
- One combinational sub-module hex_to_seg7 (nibble in, 8-bit active-low code out), reusable by other display users.
- Counter, shadow, suppression and output registers stay in the top module.

Test Plan (DIV=4, BLANK=1 unless stated):
1. Reset then scan: clr=1 for 3 cycles with data=32'h12345678, then clr=0.
   - AN=FF, SEG=FF during reset.
   - First slot: 1 cycle FF/FF, then 3 cycles AN=FE, SEG=80.
   - Next slot: 1 blank cycle, then AN=FD, SEG=F8.
   - A full frame (32 cycles) walks AN through FE..7F showing 8,7,6,5,4,3,2,1.
2. Frame latching: change data to 32'hDEADBEEF mid-frame.
   - Display keeps showing 12345678 for the rest of the frame.
   - frame_done pulses exactly once, for 1 cycle, every 32 cycles.
   - The frame after the pulse shows F,E,E,B,D,A,E,D with codes 8E,86,86,83,A1,88,86,A1.
3. Leading-zero blanking, data=32'h00000A05, blank_lz=1:
   - Digits 0,1,2 show 92, C0, 88.
   - Slots 3..7 keep AN=FF.
   - With data=0, only digit 0 shows C0.
4. No blanking, blank_lz=0, data=0: all 8 digits show C0, and AN cycles through every one-cold value.
5. Mid-frame reset during digit 5: assert clr for 1 cycle with data=32'h0000000F.
   - Next cycle AN=FF, SEG=FF.
   - Scan restarts at digit 0 with shadow=0000000F; no frame_done pulse at restart.
6. Decode sweep: run each nibble 0..F through digit 0, and check every SEG code against the table, dp=1 and the one-cold AN invariant on every cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display users: segment codes, blanking
// values and digit index width.
package seg7_pkg;

  localparam int unsigned DIGIT_W    = 3;
  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp kept off in every code.
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg7_code(input logic [3:0] nibble);
    return SEG_CODES[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment code (dp off).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = seg7_code(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode hex display driver with frame-latched
// data, per-slot blanking gap and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIV   = 100_000,
  parameter int unsigned BLANK = 1_000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] data,
  input  logic        blank_lz,
  output logic [7:0]  SEG,
  output logic [7:0]  AN,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] digit;
  logic [31:0]        shadow;

  logic       slot_end;
  logic       frame_end;
  logic       in_blank;
  logic       suppressed;
  logic [7:0] nz;
  logic [3:0] nibble;
  logic [7:0] seg_code;

  assign slot_end  = (cnt == CNT_MAX);
  assign frame_end = slot_end && (digit == DIGIT_MAX);
  assign in_blank  = (32'(cnt) < BLANK);
  assign nibble    = shadow[{digit, 2'b00} +: 4];

  always_comb begin
    nz = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nz[i] = (shadow[4*i +: 4] != 4'h0);
    end
  end

  // A digit is leading-zero iff it and every more-significant nibble is zero.
  assign suppressed = blank_lz && (digit != '0) && ((nz >> digit) == 8'h00);

  hex_to_seg7 u_decode (
    .nibble (nibble),
    .seg    (seg_code)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt        <= '0;
      digit      <= '0;
      shadow     <= data;
      AN         <= AN_OFF;
      SEG        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CNT_W'(1);
      frame_done <= frame_end;
      if (slot_end) begin
        digit <= digit + DIGIT_W'(1);
      end
      if (frame_end) begin
        shadow <= data;
      end
      if (in_blank || suppressed) begin
        AN  <= AN_OFF;
        SEG <= SEG_OFF;
      end else begin
        AN  <= ~(8'b1 << digit);
        SEG <= seg_code;
      end
    end
  end

endmodule
